// File: rtl/seq_sub_32b_pkg.sv
// Shared ALU-block definitions: FSM state encodings and default slice count.
package seq_sub_32b_pkg;

  localparam int NBYTES_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_sub_32b_subtractor_8b.sv
// Combinational 8-bit subtract slice: byte adder fed with inverted B, borrow = ~carry.
module seq_sub_32b_subtractor_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] diff,
  output logic       bout
);

  logic [8:0] sum;

  // a - b - bin == a + ~b + ~bin
  assign sum  = {1'b0, a} + {1'b0, ~b} + {8'd0, ~bin};
  assign diff = sum[7:0];
  assign bout = ~sum[8];

endmodule

// File: rtl/seq_sub_32b.sv
// Byte-serial subtractor: one 8-bit slice, borrow rippled between bytes through a register.
//
// state   | meaning
// ST_IDLE | ready, waiting for start; result/flags hold last completion
// ST_RUN  | one byte per cycle, byte k_q written into the working register
module seq_sub_32b
  import seq_sub_32b_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  ready,
  output logic                  done,
  output logic [8*NBYTES-1:0]   diff,
  output logic                  borrow,
  output logic                  zero,
  output logic                  sign,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            bin_q, bin_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            done_q, done_d;
  logic            borrow_q, borrow_d, zero_q, zero_d, sign_q, sign_d, ovf_q, ovf_d;

  logic [7:0]      a_byte, b_byte, s_byte;
  logic            s_bout;

  assign a_byte = a_q[8*k_q +: 8];
  assign b_byte = b_q[8*k_q +: 8];

  seq_sub_32b_subtractor_8b u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .bin  (bin_q),
    .diff (s_byte),
    .bout (s_bout)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    bin_d    = bin_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    diff_d   = diff_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          k_d     = '0;
          bin_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d[8*k_q +: 8] = s_byte;
        bin_d = s_bout;
        k_d   = k_q + 1'b1;
        // Last byte: publish the completed word and its flags in the same edge.
        if (k_q == K_LAST) begin
          state_d  = ST_IDLE;
          k_d      = '0;
          bin_d    = 1'b0;
          done_d   = 1'b1;
          diff_d   = work_d;
          borrow_d = s_bout;
          zero_d   = (work_d == '0);
          sign_d   = work_d[W-1];
          ovf_d    = (a_q[W-1] ^ b_q[W-1]) & (work_d[W-1] ^ a_q[W-1]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      bin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      bin_q    <= bin_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign sign   = sign_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_sub_32b.sv
// Bench for seq_sub_32b: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_seq_sub_32b;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        ready, done, borrow, zero, sign, ovf;
  logic [31:0] diff;

  int checks = 0;
  int errors = 0;

  seq_sub_32b #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .done(done), .diff(diff),
    .borrow(borrow), .zero(zero), .sign(sign), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {borrow, zero, sign, ovf, diff} from plain unsigned/signed arithmetic.
  function automatic logic [35:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    longint      sd;
    logic        of;
    r  = {1'b0, a} - {1'b0, b};
    sd = longint'($signed(a)) - longint'($signed(b));
    of = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {r[32], (r[31:0] == 32'd0), r[31], of, r[31:0]};
  endfunction

  // Cycle model: busy for NB edges after an accepted start, then one-cycle done.
  int          m_cnt = 0;
  logic [31:0] m_a, m_b;
  logic        m_done = 1'b0;
  logic [35:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_a   = A;
          m_b   = B;
          m_cnt = NB;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_res  = ref_sub(m_a, m_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_ready", {35'd0, ready}, {35'd0, (m_cnt == 0)});
      chk("cyc_done", {35'd0, done}, {35'd0, m_done});
      chk("cyc_result", {borrow, zero, sign, ovf, diff}, m_res);
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no done within %0d cycles", n);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_diff, input logic [3:0] exp_flags);
    int n;
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    wait_done(n);
    chk({name, "_latency"}, 36'(n), 36'(NB));
    chk({name, "_result"}, {borrow, zero, sign, ovf, diff}, {exp_flags, exp_diff});
  endtask

  initial begin
    int n;

    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", {ready, done, borrow, zero, sign, ovf, diff}, {1'b1, 5'b0, 32'h0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("pin_model_5_3", ref_sub(32'h5, 32'h3), {4'b0000, 32'h00000002});
    chk("pin_model_0_1", ref_sub(32'h0, 32'h1), {4'b1010, 32'hFFFFFFFF});
    chk("pin_model_ovf", ref_sub(32'h80000000, 32'h1), {4'b0001, 32'h7FFFFFFF});

    run_op("basic", 32'h00000005, 32'h00000003, 32'h00000002, 4'b0000);

    // Asynchronous reset mid-cycle, no clock edge needed.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {ready, done, borrow, zero, sign, ovf, diff}, {1'b1, 5'b0, 32'h0});
    @(negedge clk);
    rst = 1'b0;

    run_op("ripple", 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1010);
    run_op("ovf",    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001);
    run_op("equal",  32'h12345678, 32'h12345678, 32'h00000000, 4'b0100);
    run_op("neg_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1011);

    // start held during RUN with new operands; then back-to-back start in the done cycle.
    @(negedge clk);
    start = 1'b1; A = 32'd100; B = 32'd1;
    @(negedge clk);
    A = 32'hAAAA5555; B = 32'h12345678;
    wait_done(n);
    chk("hs_first", {borrow, zero, sign, ovf, diff}, {4'b0000, 32'h00000063});
    A = 32'h10; B = 32'h20;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("hs_b2b_latency", 36'(n), 36'(NB));
    chk("hs_b2b", {borrow, zero, sign, ovf, diff}, {4'b1010, 32'hFFFFFFF0});

    // Abort two cycles into an operation.
    @(negedge clk);
    start = 1'b1; A = 32'h0000FFFF; B = 32'h1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {ready, done, borrow, zero, sign, ovf, diff}, {1'b1, 5'b0, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", {35'd0, done}, 36'd0);
    end
    run_op("after_abort", 32'd9, 32'd4, 32'd5, 4'b0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
